// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_responder_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W_DEF      = 10;
    localparam int unsigned WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    // A byte address faults when it is not word aligned or lies beyond the RAM.
    function automatic logic addr_fault(input logic [DATA_W-1:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Single-port word RAM: read-first, one-cycle registered read, no reset on contents.
module word_ram
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_W-1:0]     din_i,
    output logic [DATA_W-1:0]     dout_o
);

    logic [DATA_W-1:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

    // Enabled access: old word goes to dout, new word lands in storage on a write.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= din_i;
            end
            dout_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches one MEM-stage request, waits a fixed
// latency, then completes it against word_ram or flags a fault.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_W_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_ren_i,
    input  logic              mem_wen_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic [DATA_W-1:0] mem_din_o,
    output logic              mem_stall_o,
    output logic              mem_err_o
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES) + 1;

    mem_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_q;
    logic                  fault_q;
    logic                  rd_ok_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     din_hold_q;

    logic                  req;
    logic                  fault_d;
    logic                  last_wait;
    logic                  ram_en;
    logic [DATA_W-1:0]     ram_dout;

    assign req       = mem_ren_i | mem_wen_i;
    assign fault_d   = addr_fault(mem_addr_i, ADDR_WIDTH);
    assign last_wait = (state_q == MEM_WAIT) && (cnt_q == '0);
    // Reset on the final wait cycle must drop an uncommitted write.
    assign ram_en    = last_wait && !fault_q && !rst_i;

    word_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_word_ram (
        .clk_i  (clk_i),
        .en_i   (ram_en),
        .we_i   (wr_q),
        .addr_i (waddr_q),
        .din_i  (wdata_q),
        .dout_o (ram_dout)
    );

    // Access FSM: capture request in IDLE, count down in WAIT, complete in DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            fault_q    <= 1'b0;
            rd_ok_q    <= 1'b0;
            err_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            din_hold_q <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                MEM_IDLE: begin
                    if (req) begin
                        wr_q     <= mem_wen_i;
                        waddr_q  <= mem_addr_i[ADDR_WIDTH+1:2];
                        wdata_q  <= mem_dout_i;
                        fault_q  <= fault_d;
                        cnt_q    <= CNT_W'(WAIT_CYCLES - 1);
                        state_q  <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= MEM_DONE;
                        err_q   <= fault_q;
                        rd_ok_q <= !wr_q && !fault_q;
                        if (!wr_q && fault_q) begin
                            din_hold_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                MEM_DONE: begin
                    state_q <= MEM_IDLE;
                    rd_ok_q <= 1'b0;
                    if (rd_ok_q) begin
                        din_hold_q <= ram_dout;
                    end
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    // Stall: request-driven in IDLE, held for the whole wait window.
    always_comb begin
        mem_stall_o = 1'b0;
        unique case (state_q)
            MEM_IDLE: mem_stall_o = req;
            MEM_WAIT: mem_stall_o = 1'b1;
            default:  mem_stall_o = 1'b0;
        endcase
    end

    // Fresh RAM word during a good read's DONE, otherwise the held value.
    assign mem_din_o = (state_q == MEM_DONE && rd_ok_q) ? ram_dout : din_hold_q;
    assign mem_err_o = err_q;

endmodule
